if_id_stage: RTL

//  Instruction-fetch stage between the PC register and decode. Fetches from the PC-register

---
 rtl/rv_pipe_pkg.sv | 27 ++
 rtl/if_id_stage_if.sv | 25 ++
 rtl/if_id_reg.sv | 52 +++++
 rtl/if_id_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants and encodings for the fetch stage and IF/ID register.
package rv_pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam int          PC_INC    = 4;

    // Fetch sequencer: RUN issues fetches normally, DRAIN waits out a
    // request that was in flight when a redirect arrived.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Per-cycle action applied to the IF/ID register.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctl_t;

    // Sequential successor of a PC, wrapping modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_INC);
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
interface if_id_stage_if
    import rv_pipe_pkg::*;
();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
// A bubble clears valid and the instruction but keeps the PC fields as they were.
module if_id_reg
    import rv_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  ifid_ctl_t       ctl,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr
);

    logic            id_valid_reg;
    logic [XLEN-1:0] id_pc_reg;
    logic [XLEN-1:0] id_pc_plus4_reg;
    logic [31:0]     id_instr_reg;

    // Register update: load takes the new entry, bubble squashes, hold keeps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_reg    <= 1'b0;
            id_pc_reg       <= '0;
            id_pc_plus4_reg <= '0;
            id_instr_reg    <= NOP_INSTR;
        end else begin
            case (ctl)
                IFID_LOAD: begin
                    id_valid_reg    <= 1'b1;
                    id_pc_reg       <= load_pc;
                    id_pc_plus4_reg <= pc_advance(load_pc);
                    id_instr_reg    <= load_instr;
                end
                IFID_BUBBLE: begin
                    id_valid_reg <= 1'b0;
                    id_instr_reg <= NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

    assign id_valid    = id_valid_reg;
    assign id_pc       = id_pc_reg;
    assign id_pc_plus4 = id_pc_plus4_reg;
    assign id_instr    = id_instr_reg;

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch stage: drives the PC register, talks to instruction memory
// and feeds the IF/ID register. A one-entry hold buffer keeps a fetch that
// completes while decode is stalled; DRAIN swallows a fetch that was still in
// flight when EX redirected the PC.
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt.
module if_id_stage
    import rv_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_write,
    output logic [XLEN-1:0] next_pc,
    if_id_stage_if.master   imem,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    fetch_state_t    state_reg, state_next;
    logic            hold_valid_reg, hold_valid_next;
    logic [XLEN-1:0] hold_pc_reg, hold_pc_next;
    logic [31:0]     hold_instr_reg, hold_instr_next;
    logic [XLEN-1:0] drain_addr_reg, drain_addr_next;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            complete;
    logic            pc_we;
    logic [XLEN-1:0] pc_mux;
    ifid_ctl_t       ctl;
    logic [XLEN-1:0] load_pc;
    logic [31:0]     load_instr;

    // Sequencer, hold buffer and drain address state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= RUN;
            hold_valid_reg <= 1'b0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= NOP_INSTR;
            drain_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_valid_reg <= hold_valid_next;
            hold_pc_reg    <= hold_pc_next;
            hold_instr_reg <= hold_instr_next;
            drain_addr_reg <= drain_addr_next;
        end
    end

    // Fetch request, next-PC mux, IF/ID control and next-state decisions.
    always_comb begin
        state_next      = state_reg;
        hold_valid_next = hold_valid_reg;
        hold_pc_next    = hold_pc_reg;
        hold_instr_next = hold_instr_reg;
        drain_addr_next = drain_addr_reg;
        pc_we           = 1'b0;
        pc_mux          = pc_in;
        ctl             = IFID_HOLD;
        load_pc         = pc_in;
        load_instr      = imem.imem_rdata;

        // A full hold buffer blocks new fetches until it has been consumed.
        if (state_reg == DRAIN) begin
            req  = 1'b1;
            addr = drain_addr_reg;
        end else begin
            req  = !hold_valid_reg;
            addr = pc_in;
        end
        if (reset) begin
            req = 1'b0;
        end
        complete = req & imem.imem_ready;

        if (flush_i) begin
            // Redirect beats stall and any completion: everything in IF is stale.
            ctl             = IFID_BUBBLE;
            hold_valid_next = 1'b0;
            pc_we           = 1'b1;
            pc_mux          = branch_target_i;
            if (state_reg == DRAIN) begin
                if (complete) begin
                    state_next = RUN;
                end
            end else if (req && !imem.imem_ready) begin
                // The memory keeps this address until it answers; remember it.
                drain_addr_next = pc_in;
                state_next      = DRAIN;
            end
        end else if (state_reg == DRAIN) begin
            if (complete) begin
                state_next = RUN;
            end
            ctl = stall_i ? IFID_HOLD : IFID_BUBBLE;
        end else begin
            if (complete) begin
                pc_we  = 1'b1;
                pc_mux = pc_advance(pc_in);
            end
            if (stall_i) begin
                if (complete) begin
                    hold_valid_next = 1'b1;
                    hold_pc_next    = pc_in;
                    hold_instr_next = imem.imem_rdata;
                end
            end else if (hold_valid_reg) begin
                ctl             = IFID_LOAD;
                load_pc         = hold_pc_reg;
                load_instr      = hold_instr_reg;
                hold_valid_next = 1'b0;
            end else if (complete) begin
                ctl = IFID_LOAD;
            end else begin
                ctl = IFID_BUBBLE;
            end
        end

        if (reset) begin
            pc_we = 1'b0;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;
    assign pc_write       = pc_we;
    assign next_pc        = pc_mux;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .ctl         (ctl),
        .load_pc     (load_pc),
        .load_instr  (load_instr),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_reg;
    logic [31:0] perf_bubble_cnt_reg;

    // Count valid IF/ID loads and bubble writes; both wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt_reg  <= '0;
            perf_bubble_cnt_reg <= '0;
        end else begin
            if (ctl == IFID_LOAD) begin
                perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
            end
            if (ctl == IFID_BUBBLE) begin
                perf_bubble_cnt_reg <= perf_bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = perf_fetch_cnt_reg;
    assign perf_bubble_cnt = perf_bubble_cnt_reg;
`endif

endmodule
